// File: rtl/div_seq_ctrl.sv
// Command sequencer that loads operands into the restoring divider and returns quotient/remainder.
// Optional define DIV_SEQ_OVF_CHECK_EN answers A >= M requests locally with an overflow error.
module div_seq_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2*WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0]   req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic               rsp_err,
  output logic               div_enable,
  output logic [WIDTH-1:0]   div_inbus,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_outbus
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoadA0, StLoadA1, StLoadQ, StLoadM, StWait, StCapQ, StResp
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    wd_d    = wd_q;
    valid_d = valid_q;
    err_d   = err_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_dividend[2*WIDTH-1:WIDTH];
          q_d     = req_dividend[WIDTH-1:0];
          m_d     = req_divisor;
          state_d = StLoadA0;
`ifdef DIV_SEQ_OVF_CHECK_EN
          // Quotient cannot fit in WIDTH bits (or M is zero): never start the divider.
          if (req_dividend[2*WIDTH-1:WIDTH] >= req_divisor) begin
            state_d = StResp;
            valid_d = 1'b1;
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = req_dividend[2*WIDTH-1:WIDTH];
          end
`endif
        end
      end
      StLoadA0: state_d = StLoadA1;
      StLoadA1: state_d = StLoadQ;
      StLoadQ:  state_d = StLoadM;
      StLoadM: begin
        state_d = StWait;
        wd_d    = '0;
      end
      StWait: begin
        // Done has priority over a watchdog expiry in the same cycle.
        if (div_done) begin
          rem_d   = div_outbus;
          state_d = StCapQ;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          state_d = StResp;
          valid_d = 1'b1;
          err_d   = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCapQ: begin
        quot_d  = div_outbus;
        valid_d = 1'b1;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_inbus = '0;
    unique case (state_q)
      StLoadA0, StLoadA1: div_inbus = a_q;
      StLoadQ:            div_inbus = q_q;
      StLoadM, StWait:    div_inbus = m_q;
      default:            div_inbus = '0;
    endcase
  end

  assign div_enable    = (state_q == StLoadA0);
  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = valid_q;
  assign rsp_err       = err_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: divider model, response scoreboard and directed scenarios.
// Overflow expectations follow DIV_SEQ_OVF_CHECK_EN when defined.
module tb_div_seq_ctrl;
  localparam int W  = 8;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready;
  logic [2*W-1:0] req_dividend;
  logic [W-1:0]   req_divisor;
  logic           rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic           div_enable, div_done;
  logic [W-1:0]   div_inbus, div_outbus;

  div_seq_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_enable(div_enable), .div_inbus(div_inbus),
    .div_done(div_done), .div_outbus(div_outbus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int lat = 10;       // WAIT cycle in which the divider model raises done
  int done_cyc = 0;
  int en_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [7:0] q; logic [7:0] r; logic e;} rsp_t;
  rsp_t exp_q[$];
  int   outstanding = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: latches A, A, Q, M after enable, then returns remainder with done and
  // quotient on the following cycle. It ignores rst so that stray dones can be produced.
  initial begin
    int phase = 0, cnt = 0;
    logic [7:0]  ma = 0, mq = 0, mm = 0;
    logic [15:0] dd = 0;
    div_done   = 1'b0;
    div_outbus = '0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (div_enable) begin
        ma = div_inbus;
        phase = 1;
        en_seen++;
      end else begin
        case (phase)
          1: phase = 2;
          2: begin mq = div_inbus; phase = 3; end
          3: begin mm = div_inbus; phase = 4; cnt = 0; end
          4: begin
            cnt++;
            if (cnt == lat) begin
              dd = {ma, mq};
              div_done = 1'b1;
              div_outbus = 8'(dd % 16'(mm));
              done_cyc = cyc;
              phase = 5;
            end
          end
          5: begin div_outbus = 8'(dd / 16'(mm)); phase = 0; end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard: one expected response per accepted request, from plain arithmetic.
  always @(negedge clk) begin
    rsp_t        x;
    logic [15:0] dd;
    logic [7:0]  a, m;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_div_enable", div_enable, 0);
    end else begin
      check("req_ready_vs_model", req_ready, 32'(outstanding == 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
        else begin
          check("rsp_quotient", rsp_quotient, exp_q[0].q);
          check("rsp_remainder", rsp_remainder, exp_q[0].r);
          check("rsp_err", rsp_err, exp_q[0].e);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
          end
        end
      end
      if (req_valid && req_ready) begin
        dd = req_dividend;
        a  = dd[15:8];
        m  = req_divisor;
`ifdef DIV_SEQ_OVF_CHECK_EN
        if (a >= m) x = {8'hFF, a, 1'b1};
        else
`endif
        if (lat > TO) x = {8'h00, 8'h00, 1'b1};
        else x = {8'(dd / 16'(m)), 8'(dd % 16'(m)), 1'b0};
        exp_q.push_back(x);
        outstanding++;
      end
    end
  end

  task automatic send(input logic [15:0] dd, input logic [7:0] m, output int acc);
    int t = 0;
    req_dividend = dd;
    req_divisor  = m;
    req_valid    = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_accept_wait", req_ready, 1);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [7:0] q, output logic [7:0] r,
                         output logic e, output int rc);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rsp_valid_wait", rsp_valid, 1);
    q  = rsp_quotient;
    r  = rsp_remainder;
    e  = rsp_err;
    rc = cyc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_quotient", rsp_quotient, q);
      check("hold_remainder", rsp_remainder, r);
      check("hold_err", rsp_err, e);
      check("hold_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after_rsp", req_ready, 1);
    check("rsp_valid_cleared", rsp_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] q, r;
    logic       e;
    int         ac, ac2, rc;
    logic [7:0] seq_bus [4];
    logic       seq_en  [4];
    seq_bus = '{8'h01, 8'h01, 8'h04, 8'h0A};
    seq_en  = '{1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_div_inbus", div_inbus, 0);
    check("reset_quotient", rsp_quotient, 0);
    check("reset_remainder", rsp_remainder, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 0x0104 / 0x0A: load sequence and 2-cycle done-to-response latency
    lat = 10;
    send(16'h0104, 8'h0A, ac);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("load_enable", div_enable, seq_en[i]);
      check("load_inbus", div_inbus, seq_bus[i]);
    end
    @(posedge clk);
    #1;
    get_rsp(0, q, r, e, rc);
    check("t1_quotient", q, 8'h1A);
    check("t1_remainder", r, 8'h00);
    check("t1_err", e, 0);
    check("t1_done_to_rsp", rc - done_cyc, 2);

    // 0x0064 / 0x07 with a second request waiting behind it
    lat = 5;
    send(16'h0064, 8'h07, ac);
    fork
      send(16'h0000, 8'h03, ac2);
      get_rsp(0, q, r, e, rc);
    join
    check("t2a_quotient", q, 8'h0E);
    check("t2a_remainder", r, 8'h02);
    check("t2a_err", e, 0);
    get_rsp(0, q, r, e, rc);
    check("t2b_quotient", q, 8'h00);
    check("t2b_remainder", r, 8'h00);

    // Done on the last watchdog cycle wins
    lat = TO;
    send(16'h00FF, 8'h10, ac);
    get_rsp(0, q, r, e, rc);
    check("t3_quotient", q, 8'h0F);
    check("t3_remainder", r, 8'h0F);
    check("t3_err", e, 0);
    check("t3_latency", rc - ac, 4 + TO + 2);

    // Timeout: done comes one cycle late; response held 5 cycles with rsp_ready low
    lat = TO + 1;
    send(16'h0050, 8'h09, ac);
    get_rsp(4, q, r, e, rc);
    check("t4_quotient", q, 8'h00);
    check("t4_remainder", r, 8'h00);
    check("t4_err", e, 1);
    check("t4_latency", rc - ac, 4 + TO + 1);

    // Reset in WAIT; the divider's done arrives 3 cycles after reset release
    lat = 5;
    send(16'h0123, 8'h10, ac);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_wait_inbus", div_inbus, 8'h10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_enable", div_enable, 0);
    check("t5_rst_valid", rsp_valid, 0);
    check("t5_rst_req_ready", req_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
      check("t5_idle_ready", req_ready, 1);
    end
    @(posedge clk);
    #1;

    // 0x0A00 / 0x05: overflow handling
    lat = 10;
    en_seen = 0;
    send(16'h0A00, 8'h05, ac);
    get_rsp(0, q, r, e, rc);
`ifdef DIV_SEQ_OVF_CHECK_EN
    check("t6_quotient", q, 8'hFF);
    check("t6_remainder", r, 8'h0A);
    check("t6_err", e, 1);
    check("t6_latency", rc - ac, 1);
    check("t6_enable_count", en_seen, 0);
`else
    check("t6_quotient", q, 8'h00);
    check("t6_remainder", r, 8'h00);
    check("t6_err", e, 0);
    check("t6_enable_count", en_seen, 1);
`endif

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
